// File: rtl/cache_set_array.sv
// N-way set-associative cache storage: tag/valid/dirty/data arrays with a
// registered one-cycle lookup, byte-masked write hits, victim reporting and refill.

module cache_way_cmp #(
  parameter int TAG_W = 24
) (
  input  logic             line_valid,
  input  logic [TAG_W-1:0] line_tag,
  input  logic [TAG_W-1:0] req_tag,
  output logic             match
);
  assign match = line_valid && (line_tag == req_tag);
endmodule

module cache_set_array #(
  parameter int WAYS      = 2,
  parameter int SETS      = 64,
  parameter int WORDS     = 4,
  parameter int WORD_SIZE = 32,
  parameter int TAG_W     = 24
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  input  logic                                req_type,
  input  logic [TAG_W-1:0]                    tag,
  input  logic [$clog2(SETS)-1:0]             index,
  input  logic [$clog2(WORDS)-1:0]            offset,
  input  logic [WORD_SIZE-1:0]                wdata,
  input  logic [WORD_SIZE/8-1:0]              wstrb,
  input  logic                                refill_en,
  input  logic [WORDS*WORD_SIZE-1:0]          refill_block,
  output logic                                rsp_valid,
  output logic                                hit,
  output logic [(WAYS>1?$clog2(WAYS):1)-1:0]  hit_way,
  output logic [WORD_SIZE-1:0]                rdata,
  output logic [(WAYS>1?$clog2(WAYS):1)-1:0]  victim_way,
  output logic                                victim_dirty,
  output logic [TAG_W-1:0]                    victim_tag,
  output logic [WORDS*WORD_SIZE-1:0]          victim_block
);
  localparam int BLOCK_W = WORDS * WORD_SIZE;
  localparam int OFF_W   = $clog2(WORDS);
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int STRB_W  = WORD_SIZE / 8;
  localparam int STAGES  = 1;

  logic [TAG_W-1:0]   tag_mem  [SETS][WAYS];
  logic [BLOCK_W-1:0] data_mem [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]  valid_q, dirty_q;
  logic [SETS-1:0][WAY_W-1:0] rr_q;
  logic [STAGES:1]            vld_pipe;

  logic [WAYS-1:0][TAG_W-1:0]   set_tag;
  logic [WAYS-1:0][BLOCK_W-1:0] set_data;
  logic [WAYS-1:0]              set_valid, set_dirty, match;
  logic                         hit_c, vic_found, all_valid, lookup, wr_hit;
  logic [WAY_W-1:0]             hit_way_c, vic_way;
  logic [BLOCK_W-1:0]           hit_block, merged_hit, merged_fill;
  logic [WORD_SIZE-1:0]         rd_word;

  function automatic logic [BLOCK_W-1:0] merge_word(
    input logic [BLOCK_W-1:0]   blk,
    input logic [OFF_W-1:0]     off,
    input logic [WORD_SIZE-1:0] wd,
    input logic [STRB_W-1:0]    st
  );
    logic [BLOCK_W-1:0] r;
    int base;
    r    = blk;
    base = int'(off) * WORD_SIZE;
    for (int b = 0; b < STRB_W; b++)
      if (st[b]) r[base + b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      set_tag[w]   = tag_mem[index][w];
      set_data[w]  = data_mem[index][w];
      set_valid[w] = valid_q[index][w];
      set_dirty[w] = dirty_q[index][w];
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_cmp #(.TAG_W(TAG_W)) u_cmp (
      .line_valid (set_valid[w]),
      .line_tag   (set_tag[w]),
      .req_tag    (tag),
      .match      (match[w])
    );
  end

  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = 0; w < WAYS; w++)
      if (match[w]) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
  end

  // Lowest invalid way wins; round-robin pointer only when the set is full.
  always_comb begin
    vic_way   = rr_q[index];
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!set_valid[w] && !vic_found) begin
        vic_way   = WAY_W'(w);
        vic_found = 1'b1;
      end
  end

  assign all_valid   = &set_valid;
  assign lookup      = req_valid && !refill_en;
  assign wr_hit      = lookup && req_type && hit_c;
  assign hit_block   = set_data[hit_way_c];
  assign rd_word     = hit_block[int'(offset)*WORD_SIZE +: WORD_SIZE];
  assign merged_hit  = merge_word(hit_block, offset, wdata, wstrb);
  assign merged_fill = merge_word(refill_block, offset, wdata, wstrb);
  assign rsp_valid   = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      dirty_q      <= '0;
      rr_q         <= '0;
      vld_pipe     <= '0;
      hit          <= 1'b0;
      hit_way      <= '0;
      rdata        <= '0;
      victim_way   <= '0;
      victim_dirty <= 1'b0;
      victim_tag   <= '0;
      victim_block <= '0;
    end else begin
      vld_pipe[1] <= lookup;
      if (lookup) begin
        hit          <= hit_c;
        hit_way      <= hit_way_c;
        victim_way   <= vic_way;
        victim_dirty <= set_valid[vic_way] && set_dirty[vic_way];
        victim_tag   <= set_tag[vic_way];
        victim_block <= set_data[vic_way];
        if (hit_c && !req_type) rdata <= rd_word;
      end
      if (refill_en) begin
        valid_q[index][vic_way] <= 1'b1;
        dirty_q[index][vic_way] <= req_type;
        if (WAYS > 1 && all_valid) rr_q[index] <= rr_q[index] + 1'b1;
      end else if (wr_hit) begin
        dirty_q[index][hit_way_c] <= 1'b1;
      end
    end
  end

  // Tag and data arrays survive reset; only the state bits above are cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (refill_en) begin
        tag_mem[index][vic_way]  <= tag;
        data_mem[index][vic_way] <= req_type ? merged_fill : refill_block;
      end else if (wr_hit) begin
        data_mem[index][hit_way_c] <= merged_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    assert (rst || !(req_valid && refill_en))
      else $warning("req_valid with refill_en: lookup dropped, refill taken");
    assert (rst || !lookup || $onehot0(match))
      else $error("multiple ways matched the request tag");
  end
endmodule

// File: tb/tb_cache_set_array.sv
// Directed bench for cache_set_array: a spec-level model checked every cycle
// plus literal expectations for the documented scenarios.

module tb_cache_set_array;
  localparam int WAYS = 2, SETS = 64, WORDS = 4, WORD_SIZE = 32, TAG_W = 24;
  localparam int BLOCK_W = WORDS * WORD_SIZE;
  localparam int IDX_W = $clog2(SETS), OFF_W = $clog2(WORDS), WAY_W = 1, STRB_W = 4;

  logic clk = 0, rst = 1;
  logic req_valid = 0, req_type = 0, refill_en = 0;
  logic [TAG_W-1:0] tag = '0;
  logic [IDX_W-1:0] index = '0;
  logic [OFF_W-1:0] offset = '0;
  logic [WORD_SIZE-1:0] wdata = '0;
  logic [STRB_W-1:0] wstrb = '0;
  logic [BLOCK_W-1:0] refill_block = '0;
  logic rsp_valid, hit, victim_dirty;
  logic [WAY_W-1:0] hit_way, victim_way;
  logic [WORD_SIZE-1:0] rdata;
  logic [TAG_W-1:0] victim_tag;
  logic [BLOCK_W-1:0] victim_block;

  cache_set_array #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .WORD_SIZE(WORD_SIZE), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type), .tag(tag), .index(index),
    .offset(offset), .wdata(wdata), .wstrb(wstrb), .refill_en(refill_en), .refill_block(refill_block),
    .rsp_valid(rsp_valid), .hit(hit), .hit_way(hit_way), .rdata(rdata), .victim_way(victim_way),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_block(victim_block));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Model state: one entry per line, plus the round-robin pointer per set.
  logic [TAG_W-1:0]   m_tag  [SETS][WAYS];
  logic [BLOCK_W-1:0] m_data [SETS][WAYS];
  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  bit m_wr    [SETS][WAYS];
  int m_rr    [SETS];

  bit e_rsp, e_hit, e_vdirty, e_vknown;
  int e_hit_way, e_vway;
  logic [WORD_SIZE-1:0] e_rdata;
  logic [TAG_W-1:0] e_vtag;
  logic [BLOCK_W-1:0] e_vblock;

  function automatic logic [BLOCK_W-1:0] apply_write(input logic [BLOCK_W-1:0] blk, input int off,
                                                     input logic [WORD_SIZE-1:0] wd, input logic [STRB_W-1:0] st);
    logic [WORD_SIZE-1:0] mask;
    int sh;
    mask = '0;
    for (int b = 0; b < STRB_W; b++) if (st[b]) mask[b*8 +: 8] = 8'hFF;
    sh = off * WORD_SIZE;
    return (blk & ~(BLOCK_W'(mask) << sh)) | (BLOCK_W'(wd & mask) << sh);
  endfunction

  always @(posedge clk) begin
    int idx, v, h;
    bit full;
    idx = int'(index);
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        m_rr[s] = 0;
        for (int w = 0; w < WAYS; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
      end
      e_rsp = 0; e_hit = 0; e_hit_way = 0; e_rdata = '0;
      e_vway = 0; e_vdirty = 0; e_vtag = '0; e_vblock = '0; e_vknown = 1;
    end else begin
      e_rsp = 0;
      v = -1;
      full = 1;
      for (int w = 0; w < WAYS; w++) if (!m_valid[idx][w]) begin full = 0; if (v < 0) v = w; end
      if (v < 0) v = m_rr[idx];
      if (refill_en) begin
        m_tag[idx][v]   = tag;
        m_data[idx][v]  = req_type ? apply_write(refill_block, int'(offset), wdata, wstrb) : refill_block;
        m_valid[idx][v] = 1;
        m_dirty[idx][v] = req_type;
        m_wr[idx][v]    = 1;
        if (full) m_rr[idx] = (m_rr[idx] + 1) % WAYS;
      end else if (req_valid) begin
        e_rsp = 1;
        h = -1;
        for (int w = 0; w < WAYS; w++) if (m_valid[idx][w] && m_tag[idx][w] == tag) h = w;
        e_hit     = (h >= 0);
        e_hit_way = (h >= 0) ? h : 0;
        e_vway    = v;
        e_vdirty  = m_valid[idx][v] && m_dirty[idx][v];
        e_vknown  = m_wr[idx][v];
        e_vtag    = m_tag[idx][v];
        e_vblock  = m_data[idx][v];
        if (h >= 0 && !req_type) e_rdata = WORD_SIZE'(m_data[idx][h] >> (int'(offset) * WORD_SIZE));
        if (h >= 0 && req_type) begin
          m_data[idx][h]  = apply_write(m_data[idx][h], int'(offset), wdata, wstrb);
          m_dirty[idx][h] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rsp_valid", BLOCK_W'(rsp_valid), BLOCK_W'(e_rsp));
      chk("hit", BLOCK_W'(hit), BLOCK_W'(e_hit));
      chk("hit_way", BLOCK_W'(hit_way), BLOCK_W'(e_hit_way));
      chk("rdata", BLOCK_W'(rdata), BLOCK_W'(e_rdata));
      chk("victim_way", BLOCK_W'(victim_way), BLOCK_W'(e_vway));
      chk("victim_dirty", BLOCK_W'(victim_dirty), BLOCK_W'(e_vdirty));
      if (e_vknown) begin
        chk("victim_tag", BLOCK_W'(victim_tag), BLOCK_W'(e_vtag));
        chk("victim_block", victim_block, e_vblock);
      end
    end
  end

  task automatic drive(input bit rv, input bit rt, input bit rf, input logic [TAG_W-1:0] tg, input int idx,
                       input int off, input logic [31:0] wd, input logic [3:0] ws, input logic [BLOCK_W-1:0] blk);
    req_valid = rv; req_type = rt; refill_en = rf; tag = tg;
    index = IDX_W'(idx); offset = OFF_W'(off); wdata = wd; wstrb = ws; refill_block = blk;
    @(negedge clk);
    req_valid = 0; refill_en = 0;
  endtask

  task automatic rd(input logic [TAG_W-1:0] tg, input int idx, input int off);
    drive(1, 0, 0, tg, idx, off, '0, '0, '0);
  endtask
  task automatic wr(input logic [TAG_W-1:0] tg, input int idx, input int off, input logic [31:0] wd, input logic [3:0] ws);
    drive(1, 1, 0, tg, idx, off, wd, ws, '0);
  endtask
  task automatic fill(input logic [TAG_W-1:0] tg, input int idx, input logic [BLOCK_W-1:0] blk);
    drive(0, 0, 1, tg, idx, 0, '0, '0, blk);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    rst = 0; chk_en = 1;
    chk("reset rsp_valid", BLOCK_W'(rsp_valid), 0);
    chk("reset hit", BLOCK_W'(hit), 0);
    chk("reset victim_tag", BLOCK_W'(victim_tag), 0);

    rd(24'hABCDEF, 5, 0);
    chk("cold rsp_valid", BLOCK_W'(rsp_valid), 1);
    chk("cold hit", BLOCK_W'(hit), 0);
    chk("cold victim_way", BLOCK_W'(victim_way), 0);
    chk("cold victim_dirty", BLOCK_W'(victim_dirty), 0);

    fill(24'h000011, 5, 128'h44444444_33333333_22222222_11111111);
    chk("refill no rsp", BLOCK_W'(rsp_valid), 0);
    rd(24'h000011, 5, 2);
    chk("fill hit", BLOCK_W'(hit), 1);
    chk("fill hit_way", BLOCK_W'(hit_way), 0);
    chk("fill rdata", BLOCK_W'(rdata), 32'h33333333);

    wr(24'h000011, 5, 2, 32'hDEADBEEF, 4'b0011);
    chk("wr hit", BLOCK_W'(hit), 1);
    chk("wr rdata held", BLOCK_W'(rdata), 32'h33333333);
    fill(24'h000022, 5, 128'h88888888_77777777_66666666_55555555);
    rd(24'h000011, 5, 2);
    chk("merged rdata", BLOCK_W'(rdata), 32'h3333BEEF);
    chk("dirty victim_way", BLOCK_W'(victim_way), 0);
    chk("dirty victim_dirty", BLOCK_W'(victim_dirty), 1);
    chk("dirty victim_tag", BLOCK_W'(victim_tag), 24'h000011);
    chk("dirty victim_block", victim_block, 128'h44444444_3333BEEF_22222222_11111111);

    wr(24'h000011, 5, 0, 32'hA5A5A5A5, 4'b1100);
    rd(24'h000011, 5, 0);
    chk("b2b rdata", BLOCK_W'(rdata), 32'hA5A51111);

    fill(24'hA0A0A0, 9, 128'hA3_A2_A1_A0);
    fill(24'hB0B0B0, 9, 128'hB3_B2_B1_B0);
    rd(24'hC0C0C0, 9, 0);
    chk("rr miss hit", BLOCK_W'(hit), 0);
    chk("rr victim_way 0", BLOCK_W'(victim_way), 0);
    chk("rr victim_tag A", BLOCK_W'(victim_tag), 24'hA0A0A0);
    fill(24'hC0C0C0, 9, 128'h0000000C_0000000B_0000000A_00000009);
    rd(24'hD0D0D0, 9, 0);
    chk("rr victim_way 1", BLOCK_W'(victim_way), 1);
    chk("rr victim_tag B", BLOCK_W'(victim_tag), 24'hB0B0B0);
    rd(24'hC0C0C0, 9, 1);
    chk("rr C hit_way", BLOCK_W'(hit_way), 0);
    chk("rr C rdata", BLOCK_W'(rdata), 32'h0000000A);

    drive(0, 1, 1, 24'h000077, 12, 3, 32'h12345678, 4'hF, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    rd(24'h000077, 12, 3);
    chk("alloc rdata w3", BLOCK_W'(rdata), 32'h12345678);
    rd(24'h000077, 12, 1);
    chk("alloc rdata w1", BLOCK_W'(rdata), 32'h0B0B0B0B);
    fill(24'h000088, 12, 128'h1);
    rd(24'h000099, 12, 0);
    chk("alloc victim_dirty", BLOCK_W'(victim_dirty), 1);
    chk("alloc victim_block", victim_block, 128'h12345678_0C0C0C0C_0B0B0B0B_0A0A0A0A);

    drive(1, 0, 1, 24'h000055, 20, 0, '0, '0, 128'h5);
    chk("collide no rsp", BLOCK_W'(rsp_valid), 0);
    rd(24'h000055, 20, 0);
    chk("collide installed", BLOCK_W'(hit), 1);
    chk("collide rdata", BLOCK_W'(rdata), 32'h5);

    rst = 1;
    rd(24'h000011, 5, 2);
    rst = 0;
    chk("rst rsp_valid", BLOCK_W'(rsp_valid), 0);
    chk("rst hit", BLOCK_W'(hit), 0);
    chk("rst rdata", BLOCK_W'(rdata), 0);
    chk("rst victim_dirty", BLOCK_W'(victim_dirty), 0);
    chk("rst victim_block", victim_block, 0);
    rd(24'h000011, 5, 2);
    chk("post-rst miss 5", BLOCK_W'(hit), 0);
    rd(24'hC0C0C0, 9, 1);
    chk("post-rst miss 9", BLOCK_W'(hit), 0);
    chk("post-rst victim_dirty", BLOCK_W'(victim_dirty), 0);

    @(negedge clk); @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
